// File: rtl/ahb_lite_master_issue_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_issue_if
// AHB-Lite bus bundle between the transfer-issue master and a slave.
//
// Signals:
//   HADDR/HWRITE/HSIZE/HTRANS/HBURST/HPROT/HWDATA : master -> slave
//   HREADY/HRESP/HRDATA                            : slave  -> master
//
// Modports: master (used by ahb_lite_master_issue), slave (bus model side).
// ---------------------------------------------------------------------------
interface ahb_lite_master_issue_if #(
  parameter int BUS_WIDTH = 32
);
  logic [BUS_WIDTH-1:0] HADDR;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [1:0]           HTRANS;
  logic [2:0]           HBURST;
  logic [3:0]           HPROT;
  logic [BUS_WIDTH-1:0] HWDATA;
  logic                 HREADY;
  logic                 HRESP;
  logic [BUS_WIDTH-1:0] HRDATA;

  modport master (
    output HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_master_issue.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_issue
// Pops {hwrite, hsize, haddr, hdata} entries from the transaction FIFO and
// issues them as pipelined AHB-Lite SINGLE transfers. An A-slot holds the
// transfer in its address phase, a D-slot the transfer in its data phase;
// the next address phase overlaps the current data phase. Read data is
// returned on rd_valid/rd_data; ERROR-terminated transfers pulse bus_error
// and record err_addr.
//
// Ports:
//   HCLK, reset (async, active-high)
//   fifo_empty, fifo_hwrite, fifo_hsize, fifo_haddr, fifo_hdata : FIFO head
//   fifo_pop   : combinational, consumes the head entry at this edge
//   ahb        : AHB-Lite bus (master modport)
//   rd_valid, rd_data   : completed read, one-cycle pulse
//   bus_error, err_addr : ERROR response pulse and failing address
//   busy       : either slot occupied
//   align_err  : (only with AHB_ALIGN_CHECK_EN) misaligned entry dropped
//
// Optional feature macro: AHB_ALIGN_CHECK_EN -- misaligned entries are
// popped but not issued, and align_err pulses one cycle later.
// Lane replication is defined for BUS_WIDTH = 32 only.
// ---------------------------------------------------------------------------
module ahb_lite_master_issue #(
  parameter int         BUS_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                       HCLK,
  input  logic                       reset,
  input  logic                       fifo_empty,
  input  logic                       fifo_hwrite,
  input  logic [1:0]                 fifo_hsize,
  input  logic [BUS_WIDTH-1:0]       fifo_haddr,
  input  logic [BUS_WIDTH-1:0]       fifo_hdata,
  output logic                       fifo_pop,
  ahb_lite_master_issue_if.master    ahb,
  output logic                       rd_valid,
  output logic [BUS_WIDTH-1:0]       rd_data,
  output logic                       bus_error,
  output logic [BUS_WIDTH-1:0]       err_addr,
`ifdef AHB_ALIGN_CHECK_EN
  output logic                       align_err,
`endif
  output logic                       busy
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2   // reserved, never entered
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t state_q, state_d;

  // A-slot: address phase
  logic                 a_valid;
  logic                 a_write;
  logic [1:0]           a_size;
  logic [BUS_WIDTH-1:0] a_addr;
  logic [BUS_WIDTH-1:0] a_wdata;
  // D-slot: data phase
  logic                 d_valid;
  logic                 d_write;
  logic [BUS_WIDTH-1:0] d_addr;
  logic [BUS_WIDTH-1:0] d_wdata;

  logic issue;   // popped entry is actually placed on the bus

  // Write data is lane-replicated when it enters the A-slot so HWDATA is a
  // plain register in the data phase.
  function automatic logic [BUS_WIDTH-1:0] replicate(input logic [1:0] size,
                                                     input logic [BUS_WIDTH-1:0] d);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  assign fifo_pop = !reset && !fifo_empty && (state_q == RUN) && (!a_valid || ahb.HREADY);

`ifdef AHB_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (fifo_hsize == 2'd3) ||
                      ((fifo_hsize == 2'd1) && fifo_haddr[0]) ||
                      ((fifo_hsize == 2'd2) && (fifo_haddr[1:0] != 2'b00));
  assign issue = fifo_pop && !misaligned;

  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) align_err <= 1'b0;
    else       align_err <= fifo_pop && misaligned;
  end
`else
  assign issue = fifo_pop;
`endif

  // NOTE: every sequential block updates state with non-blocking assignments
  // so all registers sample pre-edge values regardless of process order.
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // NOTE: defaults come first in this block so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ahb.HTRANS = HTRANS_IDLE;
    case (state_q)
      RUN: begin
        if (a_valid) ahb.HTRANS = HTRANS_NONSEQ;
        // First ERROR cycle: slave holds HREADY low with HRESP high.
        if (d_valid && ahb.HRESP && !ahb.HREADY) state_d = ERR1;
      end
      ERR1: begin
        // Second ERROR cycle: the pending address phase is withdrawn.
        if (ahb.HREADY) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      a_valid   <= 1'b0;
      a_write   <= 1'b0;
      a_size    <= 2'd0;
      a_addr    <= '0;
      a_wdata   <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_addr    <= '0;
      d_wdata   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      bus_error <= 1'b0;
      err_addr  <= '0;
    end else begin
      rd_valid  <= 1'b0;
      bus_error <= 1'b0;
      if (state_q == RUN) begin
        if (ahb.HREADY) begin
          if (d_valid) begin
            if (ahb.HRESP) begin
              bus_error <= 1'b1;
              err_addr  <= d_addr;
            end else if (!d_write) begin
              rd_valid <= 1'b1;
              rd_data  <= ahb.HRDATA;
            end
          end
          d_valid <= a_valid;
          if (a_valid) begin
            d_write <= a_write;
            d_addr  <= a_addr;
            d_wdata <= a_wdata;
          end
        end
        // An empty A-slot may load even while the data phase is stalled.
        if (ahb.HREADY || !a_valid) begin
          a_valid <= issue;
          if (issue) begin
            a_write <= fifo_hwrite;
            a_size  <= fifo_hsize;
            a_addr  <= fifo_haddr;
            a_wdata <= replicate(fifo_hsize, fifo_hdata);
          end
        end
      end else if (state_q == ERR1) begin
        // A-slot is held untouched and re-presented once back in RUN.
        if (ahb.HREADY) begin
          d_valid   <= 1'b0;
          bus_error <= 1'b1;
          err_addr  <= d_addr;
        end
      end
    end
  end

  assign ahb.HADDR  = a_addr;
  assign ahb.HWRITE = a_write;
  assign ahb.HSIZE  = {1'b0, a_size};
  assign ahb.HBURST = 3'b000;
  assign ahb.HPROT  = HPROT_VAL;
  assign ahb.HWDATA = d_wdata;
  assign busy       = a_valid || d_valid;

endmodule

// File: doc/ahb_lite_master_issue.md
Name: ahb_lite_master_issue

Overview:
- Downstream consumer of the transaction FIFO.
- Pops queued {hwrite, hsize, haddr, hdata} entries and drives them onto the AHB-Lite bus as pipelined SINGLE transfers. The address phase of transfer N+1 overlaps the data phase of transfer N.
- Returns read data to the requester.
- Handles wait states and the two-cycle ERROR response.

Parameters:
- BUS_WIDTH, 32, address and data width; lane logic is defined for 32 only.
- HPROT_VAL, 4'b0011, constant HPROT value.

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO has no entry; entry fields are invalid.
- fifo_hwrite  in  1  head entry: 1 = write, 0 = read.
- fifo_hsize  in  2  head entry size; `Byte=0, `Halfword=1, Word=2.
- fifo_haddr  in  BUS_WIDTH  head entry address.
- fifo_hdata  in  BUS_WIDTH  head entry write data, right-aligned.
- fifo_pop  out  1  combinational; consumes the head entry at this edge.
- HADDR  out  BUS_WIDTH  AHB address.
- HWRITE  out  1  AHB write flag.
- HSIZE  out  3  AHB size, {1'b0, size}.
- HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant HPROT_VAL.
- HWDATA  out  BUS_WIDTH  write data, lane-replicated.
- HREADY  in  1  slave ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.
- HRDATA  in  BUS_WIDTH  slave read data.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  BUS_WIDTH  completed read data.
- bus_error  out  1  one-cycle pulse per ERROR-terminated transfer.
- err_addr  out  BUS_WIDTH  address of the last ERROR-terminated transfer.
- busy  out  1  address slot or data slot occupied.

Behaviour:
- Reset values (async assert, all outputs): HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, fifo_pop=0, rd_valid=0, rd_data=0, bus_error=0, err_addr=0, busy=0.
- Reset asserted mid-transfer: both slots are flushed and the in-flight transfer is abandoned.
- Two register slots:
  - A-slot drives HADDR/HWRITE/HSIZE/HTRANS.
  - D-slot holds the transfer in its data phase and drives HWDATA.
- fifo_pop = !fifo_empty && state==RUN && (A-slot empty || HREADY).
  - On a pop, the entry loads into the A-slot and HTRANS=NONSEQ from the next cycle.
  - No pop: A-slot empties and HTRANS=IDLE.
- Phase advance: at an edge with HREADY=1, the A-slot moves to the D-slot and the D-slot retires. With HREADY=0, everything holds, including HADDR/HTRANS.
- Lane replication (registered with the entry):
  - Byte: HWDATA = {4{d[7:0]}}.
  - Halfword: HWDATA = {2{d[15:0]}}.
  - Word: HWDATA = d.
- Read retire (HREADY=1, HRESP=0, D-slot is a read): rd_data <= HRDATA and rd_valid=1 for exactly the next cycle. Latency from address-phase acceptance to rd_valid is 2 edges with zero wait states.
- Write retire: no handshake output.
- FSM states RUN, ERR1, ERR2:
  - RUN -> ERR1 when the edge samples HRESP=1 && HREADY=0 with the D-slot occupied.
  - In ERR1: HTRANS forced IDLE, pending A-slot entry held (not lost), no pops.
  - ERR1 -> RUN when the edge samples HREADY=1 (HRESP=1). At that edge: D-slot retires without rd_valid, bus_error pulses next cycle, err_addr latched.
  - After ERR1, the held A-slot entry is re-presented as NONSEQ with HADDR unchanged.
  - ERR2 is reserved and unused; any illegal state returns to RUN.
- Back-to-back: with FIFO non-empty and HREADY=1 continuously, HTRANS=NONSEQ every cycle, one pop per cycle.
- Empty FIFO with an idle bus: HTRANS=IDLE, busy=0.

Optional Feature:
- Macro: AHB_ALIGN_CHECK_EN.
- When defined: misaligned head entries (Halfword with addr[0]=1, Word with addr[1:0]!=0, or size=3) are popped but never issued. align_err (extra 1-bit output) pulses one cycle later, and the bus slot is left IDLE.
- When undefined: the align_err port is absent and every entry is issued unmodified.

Test Plan:
- Reset held, then released with FIFO empty -> HTRANS=00 and busy=0 for 5 cycles; all outputs 0 during reset.
- Write {1, 0x00000002, 0xFF, Halfword}, HREADY=1 -> HTRANS=10, HADDR=0x2, HSIZE=001 for 1 cycle; next cycle HWDATA=0x00FF00FF.
- Five queued entries (write/read alternating), HREADY=1 -> five consecutive NONSEQ cycles, five pops; each read gives rd_valid two edges after its address phase.
- Read of 0x2000 with HREADY low for 3 data-phase cycles, HRDATA=0xA5A5A5A5 -> HADDR and HWDATA held; rd_valid pulses once with rd_data=0xA5A5A5A5.
- ERROR: data phase gets HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1 -> HTRANS=IDLE in the error cycle; bus_error pulses once; err_addr equals the failing HADDR; pending transfer reissued with the same HADDR.
- With AHB_ALIGN_CHECK_EN, Word at 0x00000001 -> popped, align_err pulses once, no NONSEQ; the following aligned entry is issued normally.
